// File: rtl/demux_1xn_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1xn_fifo_if
//  Description : Ingress/egress handshake bundle of the 1-to-N FIFO demux.
//  Revision    : 1.0
// ============================================================================
interface demux_1xn_fifo_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0]       dataIn;
    logic                    validIn;
    logic [SEL_W-1:0]        selector;
    logic                    readyIn;
    logic [N_OUT*DATA_W-1:0] dataOut;
    logic [N_OUT-1:0]        validOut;
    logic [N_OUT-1:0]        readyOut;
    logic [N_OUT-1:0]        fifoFull;
    logic [CNT_W-1:0]        dropCount;

    modport master (
        output dataIn, validIn, selector, readyOut,
        input  readyIn, dataOut, validOut, fifoFull, dropCount
    );

    modport slave (
        input  dataIn, validIn, selector, readyOut,
        output readyIn, dataOut, validOut, fifoFull, dropCount
    );
endinterface
`default_nettype wire

// File: rtl/demux_1xn_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1xn_fifo
//  Description : 1-to-N demultiplexer with per-channel FWFT FIFOs, valid/ready
//                handshake and a saturating counter of out-of-range drops.
//  Revision    : 1.0
// ============================================================================
module demux_1xn_fifo #(
    parameter int DATA_W     = 8,
    parameter int N_OUT      = 4,
    parameter int SEL_W      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input wire               clk,
    input wire               reset,
    demux_1xn_fifo_if.slave  bus
);
    localparam int                c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [SEL_W:0]    c_N_OUT    = (SEL_W+1)'(N_OUT);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]  c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0]  c_CNT_FULL = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_DROP_MAX = '1;
    localparam logic [CNT_W-1:0]  c_DROP_ONE = CNT_W'(1);

    logic             w_sel_ok;
    logic             w_full_sel;
    logic             w_ready_in;
    logic             w_accept;
    logic [N_OUT-1:0] w_full;
    logic [CNT_W-1:0] r_drop_cnt;

    assign w_sel_ok = ({1'b0, bus.selector} < c_N_OUT);

    always_comb begin
        w_full_sel = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.selector == SEL_W'(k)) begin
                w_full_sel = w_full[k];
            end
        end
    end

    // Readiness looks only at fullness, never at this cycle's pop.
    assign w_ready_in    = w_sel_ok ? !w_full_sel : 1'b1;
    assign w_accept      = bus.validIn && w_ready_in;
    assign bus.readyIn   = w_ready_in;
    assign bus.fifoFull  = w_full;
    assign bus.dropCount = r_drop_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_accept && !w_sel_ok && (r_drop_cnt != c_DROP_MAX)) begin
            r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
        end
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_ch
        logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_PTR_W:0]   r_count;
        logic               w_push;
        logic               w_pop;

        assign w_push = w_accept && w_sel_ok && (bus.selector == SEL_W'(i));
        assign w_pop  = (r_count != '0) && bus.readyOut[i];

        // Storage is cleared too so the head word reads zero out of reset.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    r_mem[k] <= '0;
                end
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= bus.dataIn;
                    r_wptr        <= r_wptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end

        assign bus.dataOut[i*DATA_W +: DATA_W] = r_mem[r_rptr];
        assign bus.validOut[i]                 = (r_count != '0);
        assign w_full[i]                       = (r_count == c_CNT_FULL);
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1xn_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1xn_fifo
//  Description : Self-checking bench: queue scoreboard on a 4-channel DUT plus
//                a 3-channel DUT for out-of-range drop accounting.
//  Revision    : 1.0
// ============================================================================
module tb_demux_1xn_fifo;
    logic clk;
    logic reset;
    logic mon_en;
    int   n_checks;
    int   n_errors;

    demux_1xn_fifo_if #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) b  ();
    demux_1xn_fifo_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) b3 ();

    demux_1xn_fifo #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    demux_1xn_fifo #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .FIFO_DEPTH(4), .CNT_W(8)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        b.validIn  = v;
        b.selector = s;
        b.dataIn   = d;
        b.readyOut = r;
    endtask

    // Scoreboard: one expected-word queue per channel of the 4-channel DUT.
    logic [7:0] exp_q [4][$];

    always @(negedge clk) begin
        if (reset && mon_en) begin
            int  sel;
            bit  m_ready;
            sel     = int'(b.selector);
            m_ready = (exp_q[sel].size() < 4);
            chk("readyIn", {31'd0, b.readyIn}, {31'd0, m_ready});
            chk("dropCount", {24'd0, b.dropCount}, 32'd0);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("ch%0d validOut", i), {31'd0, b.validOut[i]},
                    {31'd0, exp_q[i].size() != 0});
                chk($sformatf("ch%0d fifoFull", i), {31'd0, b.fifoFull[i]},
                    {31'd0, exp_q[i].size() == 4});
                if (exp_q[i].size() != 0) begin
                    chk($sformatf("ch%0d dataOut", i), {24'd0, b.dataOut[8*i +: 8]},
                        {24'd0, exp_q[i][0]});
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (exp_q[i].size() != 0 && b.readyOut[i]) begin
                    void'(exp_q[i].pop_front());
                end
            end
            if (b.validIn && m_ready) begin
                exp_q[sel].push_back(b.dataIn);
            end
        end
    end

    typedef struct {
        logic       valid;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       exp_rdy_in;
        logic [3:0] exp_vout;
    } vec_t;

    vec_t tbl [7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        b3.validIn  = 1'b0;
        b3.selector = 2'd0;
        b3.dataIn   = 8'h00;
        b3.readyOut = 3'b000;

        // Reset asserted between clock edges with traffic present
        #2 reset = 1'b0;
        #1;
        chk("rst validOut", {28'd0, b.validOut}, 32'd0);
        chk("rst dataOut", b.dataOut, 32'd0);
        chk("rst dropCount", {24'd0, b.dropCount}, 32'd0);
        chk("rst readyIn", {31'd0, b.readyIn}, 32'd1);
        chk("rst fifoFull", {28'd0, b.fifoFull}, 32'd0);
        chk("rst dut3 dropCount", {24'd0, b3.dropCount}, 32'd0);
        drive(1'b1, 2'd1, 8'h55, 4'hF);
        b3.validIn  = 1'b1;
        b3.selector = 2'd3;
        repeat (2) begin
            @(negedge clk);
            chk("rst held validOut", {28'd0, b.validOut}, 32'd0);
            chk("rst held dut3 dropCount", {24'd0, b3.dropCount}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        b3.validIn = 1'b0;
        mon_en     = 1'b1;

        // Routing table: exp_vout is the state seen while that row is applied
        tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000};
        tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0001};
        tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0010};
        tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0100};
        tbl[4] = '{1'b0, 2'd2, 8'hFF, 4'hF, 1'b1, 4'b1000};
        tbl[5] = '{1'b0, 2'd1, 8'hEE, 4'hF, 1'b1, 4'b0000};
        tbl[6] = '{1'b0, 2'd3, 8'hDD, 4'h0, 1'b1, 4'b0000};
        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            drive(tbl[t].valid, tbl[t].sel, tbl[t].data, tbl[t].rdy);
            @(negedge clk); #1;
            chk($sformatf("tbl%0d readyIn", t), {31'd0, b.readyIn}, {31'd0, tbl[t].exp_rdy_in});
            chk($sformatf("tbl%0d validOut", t), {28'd0, b.validOut}, {28'd0, tbl[t].exp_vout});
        end

        // Fill channel 2 with no consumer, fifth word must be refused
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'd2, 8'hB0 + 8'(k), 4'h0);
            @(negedge clk); #1;
            chk($sformatf("full push%0d readyIn", k), {31'd0, b.readyIn}, {31'd0, k < 4});
        end
        chk("full fifoFull", {28'd0, b.fifoFull}, 32'h4);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d data", k), {24'd0, b.dataOut[23:16]}, 32'hB0 + k);
        end
        @(negedge clk);
        chk("drain empty", {31'd0, b.validOut[2]}, 32'd0);

        // Channel 1 holds two words, then push+pop every cycle across wrap
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'd1, 8'hC0 + 8'(k), 4'h0);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'd1, 8'hC2 + 8'(k), 4'b0010);
            @(negedge clk);
            chk($sformatf("conc%0d head", k), {24'd0, b.dataOut[15:8]}, 32'hC0 + k);
            chk($sformatf("conc%0d fifoFull", k), {31'd0, b.fifoFull[1]}, 32'd0);
        end
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 4'b0010);
        @(negedge clk);
        chk("conc tail0", {24'd0, b.dataOut[15:8]}, 32'hCA);
        @(negedge clk);
        chk("conc tail1", {24'd0, b.dataOut[15:8]}, 32'hCB);
        @(negedge clk);
        chk("conc empty", {31'd0, b.validOut[1]}, 32'd0);

        // Out-of-range selector on the 3-channel DUT
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            b3.validIn  = 1'b1;
            b3.selector = 2'd3;
            b3.dataIn   = 8'(k);
            b3.readyOut = 3'b000;
            @(negedge clk);
            chk("drop readyIn", {31'd0, b3.readyIn}, 32'd1);
            if (k == 0 || k == 100 || k == 255 || k == 256) begin
                chk($sformatf("drop cnt@%0d", k), {24'd0, b3.dropCount}, (k > 255) ? 32'd255 : k);
            end
        end
        @(posedge clk); #1;
        b3.validIn = 1'b0;
        @(negedge clk);
        chk("drop saturated", {24'd0, b3.dropCount}, 32'd255);
        chk("drop validOut", {29'd0, b3.validOut}, 32'd0);
        chk("drop fifoFull", {29'd0, b3.fifoFull}, 32'd0);

        // Reset mid-operation with three words queued on channel 0
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            drive(1'b1, 2'd0, 8'hD0 + 8'(k), 4'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        #1;
        chk("midrst validOut", {28'd0, b.validOut}, 32'd0);
        chk("midrst dataOut", b.dataOut, 32'd0);
        chk("midrst dut3 dropCount", {24'd0, b3.dropCount}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b1, 2'd0, 8'hD5, 4'h0);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 4'h0);
        @(negedge clk);
        chk("midrst new valid", {28'd0, b.validOut}, 32'h1);
        chk("midrst new data", {24'd0, b.dataOut[7:0]}, 32'hD5);
        @(posedge clk); #1;
        drive(1'b0, 2'd0, 8'h00, 4'h1);
        @(negedge clk);
        @(negedge clk);
        chk("midrst alone", {28'd0, b.validOut}, 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
